spell_sram_wb_bridge: RTL and testbench
=======================================

// Module: spell_sram_wb_bridge
// PURPOSE
//  Wishbone classic slave sitting directly downstream of the SPELL memory router's sram_* master port.
//  Converts each cyc/stb request into a single-port OpenRAM macro access (csb/web/wmask/addr/din/dout).
//  Sequences the macro's synchronous read latency and returns one-cycle wb_ack_o with the read data.
// PARAMETERS
//  ADDR_WIDTH    9  RAM word-address bits; wb_adr_i[ADDR_WIDTH-1:0] is the word index (no byte offset).
//  READ_LATENCY  1  Clock edges from the RAM sampling edge until ram_dout0 is valid; legal range 1..3.
// PORTS
//  clock       in   1   Single clock; all state changes on the rising edge.
//  reset       in   1   Asynchronous, active-low reset.
//  wb_cyc_i    in   1   Bus cycle active.
//  wb_stb_i    in   1   Strobe; a request exists when cyc & stb.
//  wb_we_i     in   1   1 = write, 0 = read.
//  wb_sel_i    in   4   Byte enables for writes; ignored on reads.
//  wb_adr_i    in   32  Word address.
//  wb_dat_i    in   32  Write data.
//  wb_dat_o    out  32  Read data; registered, valid while wb_ack_o is high.
//  wb_ack_o    out  1   Registered one-cycle acknowledge.
//  ram_csb0    out  1   Macro chip select, active-low.
//  ram_web0    out  1   Macro write enable, active-low.
//  ram_wmask0  out  4   Macro byte write mask.
//  ram_addr0   out  ADDR_WIDTH  Macro address.
//  ram_din0    out  32  Macro write data.
//  ram_dout0   in   32  Macro read data.
// BEHAVIOUR
//  - Reset values (applied asynchronously):
//    - wb_ack_o=0, wb_dat_o=0, ram_csb0=1, ram_web0=1, ram_wmask0=0, ram_addr0=0, ram_din0=0.
//    - FSM in IDLE.
//  - FSM states: IDLE, CMD, WAIT, ACK. Cycle 0 is the first cycle in which IDLE sees cyc & stb.
//  - IDLE, normal request (upper address bits wb_adr_i[31:ADDR_WIDTH] == 0):
//    - Register addr, din and web=~we; set wmask = we ? sel : 0 and csb=0.
//    - Next state: CMD.
//  - CMD (cycle 1): csb0 is low for exactly this cycle; the macro samples on the closing edge.
//    - Write -> ACK. Ack is high in cycle 2.
//    - Read -> WAIT.
//  - WAIT: occupies cycles 2 .. 1+READ_LATENCY; csb0=1, web0=1.
//    - On the closing edge of the last WAIT cycle, latch ram_dout0 into wb_dat_o, then go to ACK.
//    - Read ack is high in cycle 2+READ_LATENCY (cycle 3 at the default latency).
//  - ACK: wb_ack_o=1 for exactly one cycle, then IDLE.
//    - IDLE may accept a new request in the cycle immediately after ACK (back-to-back allowed).
//  - Out-of-range address (any bit of wb_adr_i[31:ADDR_WIDTH] set):
//    - No macro access; IDLE -> ACK directly, ack in cycle 1.
//    - Reads return wb_dat_o=0; writes are dropped.
//  - wb_dat_o holds the last read value; it is updated only by a read ack (zeroed on out-of-range reads).
//  - Write with wb_sel_i=0: normal timing, macro cycle issued with wmask=0.
//  - Abort: cyc low in CMD or WAIT -> IDLE on the next edge.
//    - No ack; csb0 forced high; wb_dat_o is not updated.
//    - A write already sampled by the macro stays committed.
//  - Inputs are sampled only in IDLE; changes to adr/dat/we while busy are ignored.
// CONFIGURATION
//  SPELL_SRAM_READ_CACHE_EN defined:
//    - One-entry read buffer holding {valid, addr, data}, filled on every completed read ack.
//    - Hit (read, valid, same address): IDLE -> ACK directly, ack in cycle 1, no macro access.
//    - Any accepted write, abort or reset clears valid.
//  SPELL_SRAM_READ_CACHE_EN undefined: no buffer; every in-range read takes the full FSM path.
// STRUCTURE
//  - Shared defines/package: FSM state encodings and READ_LATENCY legal-range constants.
//  - Sub-module spell_sram_rd_cache: the one-entry buffer, instantiated only under the macro.
//  - FSM, wait counter and RAM control registers stay in the top module.
// TESTING
//  - Write adr=0x05, dat=0x000000A5, sel=4'hF -> csb0=0 and web0=0 in cycle 1 with wmask=F; ack in cycle 2.
//  - Read adr=0x05 at READ_LATENCY=1 -> ack in cycle 3 with dat_o=0x000000A5; at READ_LATENCY=3 -> ack in cycle 5.
//  - Read adr=0x200 (ADDR_WIDTH=9) -> ack in cycle 1, dat_o=0, csb0 never low.
//  - Drop cyc in cycle 2 of a read -> no ack, FSM back in IDLE at cycle 3, dat_o unchanged.
//  - Assert reset low mid-WAIT -> all outputs at reset values immediately; next read is served normally.
//  - With SPELL_SRAM_READ_CACHE_EN: read 0x05 twice -> second ack in cycle 1, no csb0 pulse.
//    - Then write 0x05 and read 0x05 -> full-latency read returns the new data.

Source files
------------

// File: rtl/spell_sram_wb_bridge_pkg.sv
// Shared types and constants for the SPELL SRAM Wishbone bridge.
// The optional read buffer is enabled by defining SPELL_SRAM_READ_CACHE_EN.
package spell_sram_wb_bridge_pkg;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  // Legal range of the macro's read latency (edges from sample to dout valid)
  localparam int RL_MIN = 1;
  localparam int RL_MAX = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  // Wide enough to count down from RL_MAX-1
  typedef logic [1:0] wait_cnt_t;

endpackage

// File: rtl/spell_sram_rd_cache.sv
// One-entry read buffer {valid, addr, data} for the SPELL SRAM bridge.
// Only instantiated when SPELL_SRAM_READ_CACHE_EN is defined.
module spell_sram_rd_cache
  import spell_sram_wb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  fill,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic [DATA_W-1:0]     fill_data,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  hit,
  output logic [DATA_W-1:0]     rd_data
);

  logic                  valid;
  logic [ADDR_WIDTH-1:0] tag;
  logic [DATA_W-1:0]     data;

  // Clear wins over fill; the bridge never raises both in the same cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_addr;
      data  <= fill_data;
    end
  end

  assign hit     = valid && (tag == lookup_addr);
  assign rd_data = data;

endmodule

// File: rtl/spell_sram_wb_bridge.sv
// Wishbone classic slave -> single-port OpenRAM macro bridge.
// FSM IDLE -> CMD -> (WAIT x READ_LATENCY) -> ACK; all bus/RAM outputs registered.
// Define SPELL_SRAM_READ_CACHE_EN to add a one-entry read buffer.
module spell_sram_wb_bridge
  import spell_sram_wb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH   = 9,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [SEL_W-1:0]      wb_sel_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [DATA_W-1:0]     wb_dat_i,
  output logic [DATA_W-1:0]     wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  ram_csb0,
  output logic                  ram_web0,
  output logic [SEL_W-1:0]      ram_wmask0,
  output logic [ADDR_WIDTH-1:0] ram_addr0,
  output logic [DATA_W-1:0]     ram_din0,
  input  logic [DATA_W-1:0]     ram_dout0
);

  if (READ_LATENCY < RL_MIN || READ_LATENCY > RL_MAX) begin : g_rl_check
    $error("spell_sram_wb_bridge: READ_LATENCY out of range 1..3");
  end

  state_e    state_q, state_d;
  wait_cnt_t cnt_q, cnt_d;

  logic [DATA_W-1:0]     dat_d;
  logic                  ack_d, csb_d, web_d;
  logic [SEL_W-1:0]      wmask_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_W-1:0]     din_d;

  logic req, in_range, hit_rd;
  logic cache_hit, cache_clear, cache_fill;
  logic [DATA_W-1:0] cache_data;

  assign req      = wb_cyc_i & wb_stb_i;
  assign in_range = ~|wb_adr_i[31:ADDR_WIDTH];
  assign hit_rd   = cache_hit & in_range & ~wb_we_i;

`ifdef SPELL_SRAM_READ_CACHE_EN
  spell_sram_rd_cache #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_cache (
    .clock       (clock),
    .reset       (reset),
    .clear       (cache_clear),
    .fill        (cache_fill),
    .fill_addr   (ram_addr0),
    .fill_data   (ram_dout0),
    .lookup_addr (wb_adr_i[ADDR_WIDTH-1:0]),
    .hit         (cache_hit),
    .rd_data     (cache_data)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: out-of-range and buffer hits skip the macro entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req) state_d = (!in_range || hit_rd) ? ST_ACK : ST_CMD;
      ST_CMD:  if (!wb_cyc_i)    state_d = ST_IDLE;
               else if (!ram_web0) state_d = ST_ACK;
               else              state_d = ST_WAIT;
      ST_WAIT: if (!wb_cyc_i)    state_d = ST_IDLE;
               else if (cnt_q == '0) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of registered outputs; csb/web/wmask fall back to idle levels
  always_comb begin
    ack_d       = 1'b0;
    dat_d       = wb_dat_o;
    csb_d       = 1'b1;
    web_d       = 1'b1;
    wmask_d     = '0;
    addr_d      = ram_addr0;
    din_d       = ram_din0;
    cnt_d       = cnt_q;
    cache_clear = 1'b0;
    cache_fill  = 1'b0;
    case (state_q)
      ST_IDLE: if (req) begin
        cache_clear = wb_we_i;
        if (!in_range) begin
          ack_d = 1'b1;
          if (!wb_we_i) dat_d = '0;
        end else if (hit_rd) begin
          ack_d = 1'b1;
          dat_d = cache_data;
        end else begin
          csb_d   = 1'b0;
          web_d   = ~wb_we_i;
          wmask_d = wb_we_i ? wb_sel_i : '0;
          addr_d  = wb_adr_i[ADDR_WIDTH-1:0];
          din_d   = wb_dat_i;
        end
      end
      ST_CMD: begin
        if (!wb_cyc_i)      cache_clear = 1'b1;
        else if (!ram_web0) ack_d = 1'b1;
        else                cnt_d = wait_cnt_t'(READ_LATENCY - 1);
      end
      ST_WAIT: begin
        if (!wb_cyc_i) begin
          cache_clear = 1'b1;
        end else if (cnt_q == '0) begin
          ack_d      = 1'b1;
          dat_d      = ram_dout0;
          cache_fill = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output and wait-counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
      ram_csb0   <= 1'b1;
      ram_web0   <= 1'b1;
      ram_wmask0 <= '0;
      ram_addr0  <= '0;
      ram_din0   <= '0;
      cnt_q      <= '0;
    end else begin
      wb_ack_o   <= ack_d;
      wb_dat_o   <= dat_d;
      ram_csb0   <= csb_d;
      ram_web0   <= web_d;
      ram_wmask0 <= wmask_d;
      ram_addr0  <= addr_d;
      ram_din0   <= din_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_spell_sram_wb_bridge.sv
// Directed bench for spell_sram_wb_bridge: instance 0 at READ_LATENCY=1,
// instance 1 at READ_LATENCY=3, each with its own behavioural macro model.
module tb_spell_sram_wb_bridge;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        cyc[2], stb[2], we[2];
  logic [3:0]  sel[2];
  logic [31:0] adr[2], dat[2];
  logic [31:0] dat_o[2];
  logic        ack[2], csb[2], web[2];
  logic [3:0]  wmask[2];
  logic [8:0]  raddr[2];
  logic [31:0] din[2], dout[2];

  int errors = 0;
  int checks = 0;
  int csb_cnt[2] = '{0, 0};

  logic [31:0] mem[2][512];
  logic [31:0] pipe[2][3];

  spell_sram_wb_bridge #(.ADDR_WIDTH(9), .READ_LATENCY(1)) dut (
    .clock(clock), .reset(reset),
    .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]), .wb_sel_i(sel[0]),
    .wb_adr_i(adr[0]), .wb_dat_i(dat[0]), .wb_dat_o(dat_o[0]), .wb_ack_o(ack[0]),
    .ram_csb0(csb[0]), .ram_web0(web[0]), .ram_wmask0(wmask[0]),
    .ram_addr0(raddr[0]), .ram_din0(din[0]), .ram_dout0(dout[0])
  );

  spell_sram_wb_bridge #(.ADDR_WIDTH(9), .READ_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset),
    .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]), .wb_sel_i(sel[1]),
    .wb_adr_i(adr[1]), .wb_dat_i(dat[1]), .wb_dat_o(dat_o[1]), .wb_ack_o(ack[1]),
    .ram_csb0(csb[1]), .ram_web0(web[1]), .ram_wmask0(wmask[1]),
    .ram_addr0(raddr[1]), .ram_din0(din[1]), .ram_dout0(dout[1])
  );

  // Macro model: samples on the edge while csb low; read data emerges after
  // READ_LATENCY edges and is garbage in every other cycle.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
      pipe[k][0] <= 32'hDEAD_BEEF;
      if (!csb[k]) begin
        csb_cnt[k] <= csb_cnt[k] + 1;
        if (!web[k]) begin
          for (int b = 0; b < 4; b++)
            if (wmask[k][b]) mem[k][raddr[k]][b*8 +: 8] <= din[k][b*8 +: 8];
        end else begin
          pipe[k][0] <= mem[k][raddr[k]];
        end
      end
    end
  end
  assign dout[0] = pipe[0][0];
  assign dout[1] = pipe[1][2];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; dat[k] = d; sel[k] = s;
  endtask

  task automatic idle(input int k);
    cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0; adr[k] = '0; dat[k] = '0; sel[k] = '0;
  endtask

  // One transaction; lat = cycle index of ack (-1 if none within budget)
  task automatic xfer(input int k, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output int lat, output logic [31:0] rd, output logic c1,
                      output logic w1, output logic [3:0] m1, output int pulses);
    int c0;
    c0 = csb_cnt[k];
    lat = -1; rd = 'x; c1 = 1'b1; w1 = 1'b1; m1 = '0;
    drive(k, w, a, d, s);
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 1) begin c1 = csb[k]; w1 = web[k]; m1 = wmask[k]; end
      if (ack[k]) begin lat = n; rd = dat_o[k]; break; end
    end
    idle(k);
    tick();
    pulses = csb_cnt[k] - c0;
  endtask

  initial begin
    int lat, p;
    logic [31:0] rd;
    logic c1, w1;
    logic [3:0] m1;
    idle(0); idle(1);

    // Reset values, applied asynchronously
    #1 reset = 1'b0;
    #1;
    chk("rst_ack",   32'(ack[0]),   32'h0);
    chk("rst_dat",   dat_o[0],      32'h0);
    chk("rst_csb",   32'(csb[0]),   32'h1);
    chk("rst_web",   32'(web[0]),   32'h1);
    chk("rst_wmask", 32'(wmask[0]), 32'h0);
    chk("rst_addr",  32'(raddr[0]), 32'h0);
    chk("rst_din",   din[0],        32'h0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Full-word write, then read back at latency 1
    xfer(0, 1, 32'h05, 32'h0000_00A5, 4'hF, lat, rd, c1, w1, m1, p);
    chk("wr_lat", 32'(lat), 32'd2);
    chk("wr_csb1", 32'(c1), 32'h0);
    chk("wr_web1", 32'(w1), 32'h0);
    chk("wr_mask1", 32'(m1), 32'hF);
    chk("wr_pulses", 32'(p), 32'd1);
    xfer(0, 0, 32'h05, 32'h0, 4'h0, lat, rd, c1, w1, m1, p);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_dat", rd, 32'h0000_00A5);
    chk("rd_web1", 32'(w1), 32'h1);
    xfer(0, 0, 32'h05, 32'h0, 4'h0, lat, rd, c1, w1, m1, p);
    chk("rd2_dat", rd, 32'h0000_00A5);
`ifdef SPELL_SRAM_READ_CACHE_EN
    chk("rd2_hit_lat", 32'(lat), 32'd1);
    chk("rd2_hit_pulses", 32'(p), 32'd0);
`else
    chk("rd2_lat", 32'(lat), 32'd3);
    chk("rd2_pulses", 32'(p), 32'd1);
`endif

    // Byte-masked write: bytes 0 and 2 only
    xfer(0, 1, 32'h05, 32'h1122_3344, 4'b0101, lat, rd, c1, w1, m1, p);
    chk("pw_mask1", 32'(m1), 32'h5);
    xfer(0, 0, 32'h05, 32'h0, 4'h0, lat, rd, c1, w1, m1, p);
    chk("pw_dat", rd, 32'h0022_0044);

    // Write with sel=0: normal timing, nothing changes
    xfer(0, 1, 32'h05, 32'hFFFF_FFFF, 4'h0, lat, rd, c1, w1, m1, p);
    chk("sel0_lat", 32'(lat), 32'd2);
    chk("sel0_mask1", 32'(m1), 32'h0);
    chk("sel0_pulses", 32'(p), 32'd1);
    xfer(0, 0, 32'h05, 32'h0, 4'h0, lat, rd, c1, w1, m1, p);
    chk("sel0_dat", rd, 32'h0022_0044);

    // Top of the address range
    xfer(0, 1, 32'h1FF, 32'hCAFE_F00D, 4'hF, lat, rd, c1, w1, m1, p);
    xfer(0, 0, 32'h1FF, 32'h0, 4'h0, lat, rd, c1, w1, m1, p);
    chk("top_dat", rd, 32'hCAFE_F00D);

    // Out-of-range: immediate ack, no macro access, no aliasing onto 0x000
    xfer(0, 1, 32'h000, 32'h0BAD_C0DE, 4'hF, lat, rd, c1, w1, m1, p);
    xfer(0, 0, 32'h200, 32'h0, 4'h0, lat, rd, c1, w1, m1, p);
    chk("oor_rd_lat", 32'(lat), 32'd1);
    chk("oor_rd_dat", rd, 32'h0);
    chk("oor_rd_pulses", 32'(p), 32'd0);
    xfer(0, 1, 32'h8000_0000, 32'h1234_5678, 4'hF, lat, rd, c1, w1, m1, p);
    chk("oor_wr_lat", 32'(lat), 32'd1);
    chk("oor_wr_pulses", 32'(p), 32'd0);
    xfer(0, 0, 32'h000, 32'h0, 4'h0, lat, rd, c1, w1, m1, p);
    chk("alias_lat", 32'(lat), 32'd3);
    chk("alias_dat", rd, 32'h0BAD_C0DE);
    xfer(0, 1, 32'h001, 32'h7777_7777, 4'hF, lat, rd, c1, w1, m1, p);
    chk("hold_dat", dat_o[0], 32'h0BAD_C0DE);

    // Abort: drop cyc in cycle 2 of a read; IDLE again in cycle 3
    drive(0, 0, 32'h1FF, 32'h0, 4'h0);
    tick(); tick();
    idle(0);
    tick();
    chk("abort_ack", 32'(ack[0]), 32'h0);
    chk("abort_dat", dat_o[0], 32'h0BAD_C0DE);
    xfer(0, 0, 32'h05, 32'h0, 4'h0, lat, rd, c1, w1, m1, p);
    chk("post_abort_lat", 32'(lat), 32'd3);
    chk("post_abort_dat", rd, 32'h0022_0044);

    // Latency 3 instance
    xfer(1, 1, 32'h05, 32'h0000_00A5, 4'hF, lat, rd, c1, w1, m1, p);
    chk("rl3_wr_lat", 32'(lat), 32'd2);
    xfer(1, 0, 32'h05, 32'h0, 4'h0, lat, rd, c1, w1, m1, p);
    chk("rl3_rd_lat", 32'(lat), 32'd5);
    chk("rl3_rd_dat", rd, 32'h0000_00A5);

    // Reset in the middle of WAIT
    drive(1, 0, 32'h05, 32'h0, 4'h0);
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    chk("mrst_ack",  32'(ack[1]),   32'h0);
    chk("mrst_dat",  dat_o[1],      32'h0);
    chk("mrst_csb",  32'(csb[1]),   32'h1);
    chk("mrst_addr", 32'(raddr[1]), 32'h0);
    chk("mrst_dat0", dat_o[0],      32'h0);
    idle(1);
    tick();
    reset = 1'b1;
    tick();
    xfer(1, 0, 32'h05, 32'h0, 4'h0, lat, rd, c1, w1, m1, p);
    chk("mrst_rd_lat", 32'(lat), 32'd5);
    chk("mrst_rd_dat", rd, 32'h0000_00A5);

`ifdef SPELL_SRAM_READ_CACHE_EN
    // Hit after fill, then a write invalidates the buffer
    xfer(0, 0, 32'h1FF, 32'h0, 4'h0, lat, rd, c1, w1, m1, p);
    chk("c_fill_lat", 32'(lat), 32'd3);
    xfer(0, 0, 32'h1FF, 32'h0, 4'h0, lat, rd, c1, w1, m1, p);
    chk("c_hit_lat", 32'(lat), 32'd1);
    chk("c_hit_dat", rd, 32'hCAFE_F00D);
    xfer(0, 1, 32'h1FF, 32'h600D_F00D, 4'hF, lat, rd, c1, w1, m1, p);
    xfer(0, 0, 32'h1FF, 32'h0, 4'h0, lat, rd, c1, w1, m1, p);
    chk("c_inv_lat", 32'(lat), 32'd3);
    chk("c_inv_dat", rd, 32'h600D_F00D);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
